// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream MSB-first into 32-bit words and issues one-cycle instruction-memory writes.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: trailing checksum word compared against the sum of written words.
module imem_loader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 100,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_W-1:0]     num_words,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [31:0]          wr_addr,
  output logic [MEM_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     words_done
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  state_t               state, state_nx;
  logic [31:0]          cur_addr;
  logic                 addr_ovf;
  logic [CNT_W-1:0]     num_lat;
  logic [1:0]           byte_cnt;
  logic [MEM_WIDTH-1:0] word;
  logic [MEM_WIDTH-1:0] word_nx;
  logic                 accept;
  logic                 last_byte;
  logic                 oob;
  logic                 last_word;
  logic [32:0]          addr_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] sum;
`endif

  assign accept    = in_valid & in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign word_nx   = {word[MEM_WIDTH-9:0], in_data};
  assign addr_inc  = {1'b0, cur_addr} + 33'd4;
  assign last_word = (words_done + CNT_W'(1)) == num_lat;
  // A carry out of the address adder is sticky so a wrapped address can never look in range.
  assign oob       = addr_ovf || ({2'b00, cur_addr[31:2]} > 32'(MEM_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words == '0 || base_addr[1:0] != 2'b00) state_nx = DONE;
          else                                            state_nx = RECV;
        end
      end
      RECV: if (last_byte) state_nx = WRITE;
      WRITE: begin
        if (oob)            state_nx = DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if (last_word) state_nx = CHECK;
`else
        else if (last_word) state_nx = DONE;
`endif
        else                state_nx = RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (last_byte) state_nx = DONE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      RECV:  in_ready = 1'b1;
      WRITE: wr_en    = !oob;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: in_ready = 1'b1;
`endif
      DONE:  done     = 1'b1;
      default: ;
    endcase
    wr_addr = wr_en ? cur_addr : '0;
    wr_data = wr_en ? word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      addr_ovf   <= 1'b0;
      num_lat    <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      err        <= 1'b0;
      words_done <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        cur_addr   <= base_addr;
        addr_ovf   <= 1'b0;
        num_lat    <= num_words;
        byte_cnt   <= '0;
        word       <= '0;
        words_done <= '0;
        err        <= (num_words != '0) && (base_addr[1:0] != 2'b00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end
      if (accept) begin
        word     <= word_nx;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == WRITE) begin
        if (oob) begin
          err <= 1'b1;
        end else begin
          cur_addr   <= addr_inc[31:0];
          addr_ovf   <= addr_ovf | addr_inc[32];
          words_done <= words_done + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum        <= sum + word;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CHECK && last_byte && word_nx != sum) err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: constant vector table, hand sequences for reset abort
// and checksum, and randomized loads compared against a word-level reference model.
module tb_imem_loader;
  localparam int MEM_DEPTH = 100;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [CNT_W-1:0] num_words = '0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, wr_en, busy, done, err;
  logic [31:0]      wr_addr, wr_data;
  logic [CNT_W-1:0] words_done;

  always #5 clk = ~clk;

  imem_loader #(.MEM_WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
    .words_done(words_done)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]       stream[$];
  logic [31:0]      obs_a[$], obs_d[$];
  logic             obs_err;
  logic [CNT_W-1:0] obs_wd;
  logic [31:0]      exp_a[$], exp_d[$];
  logic             m_err;
  int               m_wd;

  typedef struct {
    logic [31:0] base;
    int          num;
    int          gap;
    bit          poke;
    int          exp_wd;
    logic        exp_err;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
  endfunction

  // Stream of 4*num data bytes; pattern 0 starts with the reference bytes 20 08 00 05 20 09 00 0A.
  task automatic make_stream(input int num, input bit rnd);
    logic [7:0] pat[8];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] s;
`endif
    pat = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    stream.delete();
    for (int k = 0; k < 4*num; k++)
      stream.push_back(rnd ? 8'($urandom) : (k < 8 ? pat[k] : 8'(k)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '0;
    for (int i = 0; i < num; i++) s += word_at(i);
    stream.push_back(s[31:24]); stream.push_back(s[23:16]);
    stream.push_back(s[15:8]);  stream.push_back(s[7:0]);
`endif
  endtask

  // Reference model: which words land where, final error and word count.
  task automatic model(input logic [31:0] base, input int num);
    logic [63:0] a;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] s;
`endif
    exp_a.delete(); exp_d.delete(); m_err = 1'b0; m_wd = 0;
    if (num == 0) return;
    if (base % 4 != 0) begin m_err = 1'b1; return; end
    for (int i = 0; i < num; i++) begin
      a = {32'b0, base} + 64'(4*i);
      if (a / 4 > 64'(MEM_DEPTH - 1)) begin m_err = 1'b1; return; end
      exp_a.push_back(a[31:0]);
      exp_d.push_back(word_at(i));
      m_wd++;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '0;
    foreach (exp_d[i]) s += exp_d[i];
    if (s != word_at(num)) m_err = 1'b1;
`endif
  endtask

  // gap: 0 continuous, 1 valid every other cycle, 2 random. poke: stray start mid-load.
  task automatic run_load(input logic [31:0] base, input int num, input int gap, input bit poke);
    int  idx, cyc;
    bit  got, prev4, vld;
    obs_a.delete(); obs_d.delete();
    obs_err = 1'b0; obs_wd = '0;
    idx = 0; cyc = 0; got = 0; prev4 = 0;
    @(negedge clk);
    base_addr = base; num_words = CNT_W'(num); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got && cyc < 1000) begin
      if (wr_en) begin
        obs_a.push_back(wr_addr); obs_d.push_back(wr_data);
        chk("wr_latency", {63'b0, prev4}, 64'd1);
      end
      if (done) begin got = 1; obs_err = err; obs_wd = words_done; end
      vld = (idx < stream.size()) &&
            (gap == 0 || (gap == 1 && cyc % 2 == 0) || (gap == 2 && $urandom_range(0, 1) == 1));
      in_valid = vld;
      in_data  = vld ? stream[idx] : 8'($urandom);
      start    = poke && (cyc == 3);
      if (poke && cyc == 3) begin base_addr = 32'h100; num_words = CNT_W'(1); end
      prev4 = vld && in_ready && (idx % 4 == 3);
      if (vld && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("done_seen", {63'b0, got}, 64'd1);
    chk("done_pulse", {63'b0, done}, 64'd0);
    chk("busy_after", {63'b0, busy}, 64'd0);
  endtask

  task automatic check_load(input string name, input logic [31:0] base, input int num);
    model(base, num);
    chk({name, "/err"}, {63'b0, obs_err}, {63'b0, m_err});
    chk({name, "/words_done"}, 64'(obs_wd), 64'(m_wd));
    chk({name, "/nwrites"}, 64'(obs_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      chk({name, "/wr_addr"}, 64'(obs_a[i]), 64'(exp_a[i]));
      chk({name, "/wr_data"}, 64'(obs_d[i]), 64'(exp_d[i]));
    end
  endtask

  initial begin
    logic [31:0] rb;
    int          rn, sel, idx, cyc, wcnt;

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_words_done", 64'(words_done), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{32'h0,        2, 0, 1'b0, 2, 1'b0, 32'h20080005, 32'h2009000A};
    vecs[1] = '{32'h0,        2, 1, 1'b0, 2, 1'b0, 32'h20080005, 32'h2009000A};
    vecs[2] = '{32'h18C,      2, 0, 1'b0, 1, 1'b1, 32'h20080005, 32'h0};
    vecs[3] = '{32'h0,        0, 0, 1'b0, 0, 1'b0, 32'h0,        32'h0};
    vecs[4] = '{32'h2,        1, 0, 1'b0, 0, 1'b1, 32'h0,        32'h0};
    vecs[5] = '{32'h40,       3, 2, 1'b1, 3, 1'b0, 32'h20080005, 32'h2009000A};
    vecs[6] = '{32'h190,      1, 0, 1'b0, 0, 1'b1, 32'h0,        32'h0};
    vecs[7] = '{32'hFFFFFFFC, 1, 0, 1'b0, 0, 1'b1, 32'h0,        32'h0};
    for (int v = 0; v < 8; v++) begin
      make_stream(vecs[v].num, 1'b0);
      run_load(vecs[v].base, vecs[v].num, vecs[v].gap, vecs[v].poke);
      check_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].num);
      chk($sformatf("vec%0d/tbl_err", v), {63'b0, obs_err}, {63'b0, vecs[v].exp_err});
      chk($sformatf("vec%0d/tbl_wd", v), 64'(obs_wd), 64'(vecs[v].exp_wd));
      chk($sformatf("vec%0d/tbl_w0", v), 64'(obs_d.size() > 0 ? obs_d[0] : 32'h0), 64'(vecs[v].exp_w0));
      chk($sformatf("vec%0d/tbl_w1", v), 64'(obs_d.size() > 1 ? obs_d[1] : 32'h0), 64'(vecs[v].exp_w1));
    end

    // Reset abort after 6 bytes of a 3-word load.
    make_stream(3, 1'b1);
    @(negedge clk);
    base_addr = 32'h0; num_words = CNT_W'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 100) begin
      in_valid = 1'b1; in_data = stream[idx];
      if (in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("t5_wd_before", 64'(words_done), 64'd1);
    chk("t5_busy_before", {63'b0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", {63'b0, busy}, 64'd0);
    chk("t5_in_ready", {63'b0, in_ready}, 64'd0);
    chk("t5_wr_en", {63'b0, wr_en}, 64'd0);
    chk("t5_words_done", 64'(words_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wcnt = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
      if (wr_en) wcnt++;
    end
    in_valid = 1'b0;
    chk("t5_no_write", 64'(wcnt), 64'd0);
    make_stream(2, 1'b0);
    run_load(32'h0, 2, 0, 1'b0);
    check_load("t5_after", 32'h0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    run_load(32'h0, 2, 0, 1'b0);
    chk("t6_good_err", {63'b0, obs_err}, 64'd0);
    chk("t6_good_nwrites", 64'(obs_a.size()), 64'd2);
    stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04};
    run_load(32'h0, 2, 0, 1'b0);
    chk("t6_bad_err", {63'b0, obs_err}, 64'd1);
    chk("t6_bad_nwrites", 64'(obs_a.size()), 64'd2);
`endif

    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      rb = 32'($urandom_range(0, 400));
      else if (sel <= 2) rb = 32'h170 + 32'(4 * $urandom_range(0, 12));
      else if (sel == 3) rb = 32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3));
      else               rb = 32'(4 * $urandom_range(0, 60));
      rn = $urandom_range(0, 5);
      make_stream(rn, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) stream[stream.size()-1] = stream[stream.size()-1] ^ 8'h01;
`endif
      run_load(rb, rn, $urandom_range(0, 2), 1'b0);
      check_load("rnd", rb, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
